friet_c_lwc_stream_arbiter: RTL and testbench
=============================================

Name: friet_c_lwc_stream_arbiter

Overview:
- Two-requester packet arbiter in front of the FRIET-C LWC core input.
- Merges the PDI (requester 0) and SDI (requester 1) streams, each delivered through an input skid buffer, into one valid/ready stream.
- Each packet is one header word followed by N payload words. N sits in the header's low length field.
- Grant is round-robin and is locked for a whole packet, so header and payload are never interleaved.

Parameters:
G_WIDTH, 32, data word width of all streams
G_LEN_WIDTH, 16, width of the length field in header bits [G_LEN_WIDTH-1:0]; must be <= G_WIDTH

Ports:
clk  in  1  clock
rst  in  1  reset
din0  in  G_WIDTH  requester 0 (PDI) data
din0_valid  in  1  requester 0 valid
din0_ready  out  1  requester 0 ready
din1  in  G_WIDTH  requester 1 (SDI) data
din1_valid  in  1  requester 1 valid
din1_ready  out  1  requester 1 ready
dout  out  G_WIDTH  merged data toward the core
dout_valid  out  1  merged valid
dout_ready  in  1  core ready
dout_src  out  1  source of the current dout word (0/1)
dout_last  out  1  current dout word is the final word of its packet
busy  out  1  state != S_IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Next state S_IDLE, grant=0, last_grant=1 (requester 0 wins the first tie), count=0.
  - While rst=1: din0_ready=din1_ready=0 and dout_valid=0, combinationally, regardless of state. No transfer completes in a reset cycle.
  - Reset mid-packet abandons the packet. Remaining payload words stay upstream and are later treated as a new header. Resynchronising is the upstream's job.
- Transfer rules: a transfer on a port occurs when valid & ready are both 1 at a clk edge. dout-side transfer = dout_valid & dout_ready.
- S_IDLE:
  - dout_valid=0, both din ready=0.
  - Only din0 valid: grant<=0.
  - Only din1 valid: grant<=1.
  - Both valid: grant<=~last_grant.
  - Go to S_HEADER whenever any valid; otherwise stay.
  - Arbitration costs one bubble cycle per packet.
- S_HEADER and S_PAYLOAD (granted side only):
  - dout = din[grant], dout_valid = din_valid[grant], din_ready[grant] = dout_ready, dout_src = grant.
  - Non-granted ready = 0.
  - Pass-through path is purely combinational, zero added latency.
- S_HEADER, on dout transfer:
  - len = header[G_LEN_WIDTH-1:0].
  - len==0: dout_last=1, last_grant<=grant, go to S_IDLE.
  - Otherwise: count<=len, go to S_PAYLOAD.
  - dout_last=0 on a header with len!=0.
- S_PAYLOAD, on each dout transfer:
  - count==1: dout_last=1, last_grant<=grant, go to S_IDLE.
  - Otherwise: count<=count-1.
  - dout_last = (count==1) whenever dout_valid.
- Source stalls (granted valid=0) hold the state and count indefinitely. The other requester is never served during a stall.
- Maximum payload is 2^G_LEN_WIDTH-1 words. The count register is G_LEN_WIDTH bits and never wraps, because it exits at 1.
- last_grant updates only on packet completion, so a requester cannot starve: after its packet, a contending requester is served next.
- dout_last and dout_src are don't-care while dout_valid=0; the bench must not check them then.
- When outputs are forced because rst=1, the state does not matter.

Decomposition:
- Shared package friet_c_lwc_pkg:
  - State encodings S_IDLE=2'd0, S_HEADER=2'd1, S_PAYLOAD=2'd2 (2'd3 goes to S_IDLE).
  - Source ids SRC_PDI=1'b0, SRC_SDI=1'b1.
  - Default widths.
- No sub-module is needed. The pure round-robin grant function (two valids + last_grant -> grant) may be split out as friet_c_lwc_rr_pick for standalone checking.

Test Plan:
- After reset, din0 sends header 0x0000_0002 + payloads 0xA1, 0xA2, dout_ready=1:
  - dout carries 3 words, src=0.
  - dout_last only on 0xA2.
  - busy drops the cycle after.
  - First dout_valid occurs 1 cycle after din0_valid rises.
- Both requesters hold headers with len=1 simultaneously after reset:
  - Order is src0 packet, then src1 packet.
  - A repeat tie then grants src0 again after src1 completes.
  - din1_ready=0 throughout src0's packet.
- Header 0x1234_0000 (len=0) on din1 -> single word with dout_last=1, src=1, return to S_IDLE.
- dout_ready toggling 1/0 each cycle during a 4-word payload:
  - Data order is preserved and no word is duplicated or dropped.
  - din ready mirrors dout_ready exactly.
- Granted source drops valid for 5 cycles mid-payload while the other is valid -> no grant switch, count held, packet resumes intact.
- rst=1 for one cycle after 2 of 4 payload words:
  - Both readys=0 and dout_valid=0 in that cycle.
  - Afterwards busy=0.
  - The next word offered is treated as a header: len taken from its low 16 bits.

Source files
------------

// File: rtl/friet_c_lwc_pkg.sv
// Shared types and constants for the FRIET-C LWC input-side stream blocks.
package friet_c_lwc_pkg;

    localparam int C_WIDTH     = 32;
    localparam int C_LEN_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2
    } arb_state_t;

    localparam logic SRC_PDI = 1'b0;
    localparam logic SRC_SDI = 1'b1;

endpackage

// File: rtl/friet_c_lwc_rr_pick.sv
// Round-robin pick between two requesters: a tie goes to the side that did not win last.
// Purely combinational, no state.
module friet_c_lwc_rr_pick
    import friet_c_lwc_pkg::*;
(
    input  logic i_vld0,
    input  logic i_vld1,
    input  logic i_last_grant,
    output logic o_grant
);

    assign o_grant = (i_vld1 && (!i_vld0 || (i_last_grant == SRC_PDI))) ? SRC_SDI : SRC_PDI;

endmodule

// File: rtl/friet_c_lwc_stream_arbiter.sv
// Packet-locked round-robin merge of PDI/SDI streams; one idle bubble per packet for arbitration,
// then zero-latency combinational pass-through with ready steered to the granted side only.
module friet_c_lwc_stream_arbiter
    import friet_c_lwc_pkg::*;
#(
    parameter int G_WIDTH     = C_WIDTH,
    parameter int G_LEN_WIDTH = C_LEN_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [G_WIDTH-1:0] din0,
    input  logic               din0_valid,
    output logic               din0_ready,
    input  logic [G_WIDTH-1:0] din1,
    input  logic               din1_valid,
    output logic               din1_ready,
    output logic [G_WIDTH-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_src,
    output logic               dout_last,
    output logic               busy
);

    localparam logic [G_LEN_WIDTH-1:0] C_ONE = {{(G_LEN_WIDTH-1){1'b0}}, 1'b1};

    arb_state_t             r_state, w_state_nxt;
    logic                   r_grant, w_grant_nxt;
    logic                   r_last_grant, w_last_grant_nxt;
    logic [G_LEN_WIDTH-1:0] r_count, w_count_nxt;

    logic [G_WIDTH-1:0]     w_sel_dat;
    logic                   w_sel_vld;
    logic                   w_active;
    logic                   w_xfer;
    logic                   w_pick;
    logic [G_LEN_WIDTH-1:0] w_len;

    friet_c_lwc_rr_pick u_rr_pick (
        .i_vld0       (din0_valid),
        .i_vld1       (din1_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick)
    );

    assign w_sel_dat = (r_grant == SRC_SDI) ? din1 : din0;
    assign w_sel_vld = (r_grant == SRC_SDI) ? din1_valid : din0_valid;
    assign w_len     = w_sel_dat[G_LEN_WIDTH-1:0];

    // Reset overrides the handshake outputs so nothing can complete in a reset cycle.
    assign w_active  = !rst && ((r_state == S_HEADER) || (r_state == S_PAYLOAD));

    assign dout       = w_sel_dat;
    assign dout_valid = w_active && w_sel_vld;
    assign dout_src   = r_grant;
    assign din0_ready = w_active && (r_grant == SRC_PDI) && dout_ready;
    assign din1_ready = w_active && (r_grant == SRC_SDI) && dout_ready;
    assign w_xfer     = dout_valid && dout_ready;
    assign busy       = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_count_nxt      = r_count;
        dout_last        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (din0_valid || din1_valid) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                dout_last = (w_len == '0);
                if (w_xfer) begin
                    if (w_len == '0) begin
                        w_last_grant_nxt = r_grant;
                        w_state_nxt      = S_IDLE;
                    end else begin
                        w_count_nxt = w_len;
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                // Exits at one, so the counter never has to wrap through zero.
                dout_last = (r_count == C_ONE);
                if (w_xfer) begin
                    if (r_count == C_ONE) begin
                        w_last_grant_nxt = r_grant;
                        w_state_nxt      = S_IDLE;
                    end else begin
                        w_count_nxt = r_count - C_ONE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= SRC_PDI;
            r_last_grant <= SRC_SDI;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_count      <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_friet_c_lwc_stream_arbiter.sv
// Directed, table-driven bench for the two-requester packet arbiter.
module tb_friet_c_lwc_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din0 = '0, din1 = '0;
    logic        din0_valid = 1'b0, din1_valid = 1'b0, dout_ready = 1'b0;
    logic        din0_ready, din1_ready, dout_valid, dout_src, dout_last, busy;
    logic [31:0] dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    friet_c_lwc_stream_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .din0       (din0),
        .din0_valid (din0_valid),
        .din0_ready (din0_ready),
        .din1       (din1),
        .din1_valid (din1_valid),
        .din1_ready (din1_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_src   (dout_src),
        .dout_last  (dout_last),
        .busy       (busy)
    );

    typedef struct {
        logic        rst;
        logic [31:0] d0;
        logic        v0;
        logic [31:0] d1;
        logic        v1;
        logic        rdy;
        logic        ck_busy;
        logic        busy;
        logic        vld;
        logic        r0;
        logic        r1;
        logic [31:0] dat;
        logic        src;
        logic        last;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, input logic [31:0] d0, input logic v0,
                     input logic [31:0] d1, input logic v1, input logic rdy,
                     input logic ckb, input logic eb, input logic evld,
                     input logic er0, input logic er1, input logic [31:0] edat,
                     input logic esrc, input logic elast);
        vec_t t;
        t.rst = r; t.d0 = d0; t.v0 = v0; t.d1 = d1; t.v1 = v1; t.rdy = rdy;
        t.ck_busy = ckb; t.busy = eb; t.vld = evld; t.r0 = er0; t.r1 = er1;
        t.dat = edat; t.src = esrc; t.last = elast;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge; outputs are sampled at the falling edge.
    task automatic cyc(input logic r, input logic [31:0] d0, input logic v0,
                       input logic [31:0] d1, input logic v1, input logic rdy);
        @(posedge clk);
        #1;
        rst = r; din0 = d0; din0_valid = v0; din1 = d1; din1_valid = v1; dout_ready = rdy;
        @(negedge clk);
    endtask

    task automatic chk_word(input string nm, input logic [31:0] dat, input logic src, input logic last);
        chk({nm, " vld"},  {31'b0, dout_valid}, 32'd1);
        chk({nm, " dat"},  dout, dat);
        chk({nm, " src"},  {31'b0, dout_src}, {31'b0, src});
        chk({nm, " last"}, {31'b0, dout_last}, {31'b0, last});
    endtask

    initial begin
        // rst d0 v0 d1 v1 rdy | ckb busy vld r0 r1 dat src last
        // single din0 packet, len=2
        v(1, 32'h2, 1, 32'h0, 0, 1,  0, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h0, 0, 32'h0, 0, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h2, 1, 32'h0, 0, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h2, 1, 32'h0, 0, 1,  1, 1, 1, 1, 0, 32'h2, 0, 0);
        v(0, 32'hA1, 1, 32'h0, 0, 1, 1, 1, 1, 1, 0, 32'hA1, 0, 0);
        v(0, 32'hA2, 1, 32'h0, 0, 1, 1, 1, 1, 1, 0, 32'hA2, 0, 1);
        v(0, 32'h0, 0, 32'h0, 0, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);
        // tie after reset: src0, src1, then src0 again
        v(1, 32'h1, 1, 32'h1, 1, 1,  0, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h1, 1, 32'h1, 1, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h1, 1, 32'h1, 1, 1,  1, 1, 1, 1, 0, 32'h1, 0, 0);
        v(0, 32'hB0, 1, 32'h1, 1, 1, 1, 1, 1, 1, 0, 32'hB0, 0, 1);
        v(0, 32'h1, 1, 32'h1, 1, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h1, 1, 32'h1, 1, 1,  1, 1, 1, 0, 1, 32'h1, 1, 0);
        v(0, 32'h1, 1, 32'hC0, 1, 1, 1, 1, 1, 0, 1, 32'hC0, 1, 1);
        v(0, 32'h1, 1, 32'h1, 1, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h1, 1, 32'h1, 1, 1,  1, 1, 1, 1, 0, 32'h1, 0, 0);
        v(0, 32'hB1, 1, 32'h0, 0, 1, 1, 1, 1, 1, 0, 32'hB1, 0, 1);
        v(0, 32'h0, 0, 32'h0, 0, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);
        // len=0 header on din1
        v(0, 32'h0, 0, 32'h12340000, 1, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h0, 0, 32'h12340000, 1, 1, 1, 1, 1, 0, 1, 32'h12340000, 1, 1);
        v(0, 32'h0, 0, 32'h0, 0, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);
        // dout_ready toggling over a 4-word payload
        v(0, 32'h4, 1, 32'h0, 0, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h4, 1, 32'h0, 0, 0,  1, 1, 1, 0, 0, 32'h4, 0, 0);
        v(0, 32'h4, 1, 32'h0, 0, 1,  1, 1, 1, 1, 0, 32'h4, 0, 0);
        v(0, 32'hD1, 1, 32'h0, 0, 0, 1, 1, 1, 0, 0, 32'hD1, 0, 0);
        v(0, 32'hD1, 1, 32'h0, 0, 1, 1, 1, 1, 1, 0, 32'hD1, 0, 0);
        v(0, 32'hD2, 1, 32'h0, 0, 0, 1, 1, 1, 0, 0, 32'hD2, 0, 0);
        v(0, 32'hD2, 1, 32'h0, 0, 1, 1, 1, 1, 1, 0, 32'hD2, 0, 0);
        v(0, 32'hD3, 1, 32'h0, 0, 0, 1, 1, 1, 0, 0, 32'hD3, 0, 0);
        v(0, 32'hD3, 1, 32'h0, 0, 1, 1, 1, 1, 1, 0, 32'hD3, 0, 0);
        v(0, 32'hD4, 1, 32'h0, 0, 0, 1, 1, 1, 0, 0, 32'hD4, 0, 1);
        v(0, 32'hD4, 1, 32'h0, 0, 1, 1, 1, 1, 1, 0, 32'hD4, 0, 1);
        v(0, 32'h0, 0, 32'h0, 0, 1,  1, 0, 0, 0, 0, 32'h0, 0, 0);

        foreach (vq[i]) begin
            cyc(vq[i].rst, vq[i].d0, vq[i].v0, vq[i].d1, vq[i].v1, vq[i].rdy);
            if (vq[i].ck_busy)
                chk($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, vq[i].busy});
            chk($sformatf("v%0d vld", i), {31'b0, dout_valid}, {31'b0, vq[i].vld});
            chk($sformatf("v%0d rdy0", i), {31'b0, din0_ready}, {31'b0, vq[i].r0});
            chk($sformatf("v%0d rdy1", i), {31'b0, din1_ready}, {31'b0, vq[i].r1});
            if (vq[i].vld) begin
                chk($sformatf("v%0d dat", i), dout, vq[i].dat);
                chk($sformatf("v%0d src", i), {31'b0, dout_src}, {31'b0, vq[i].src});
                chk($sformatf("v%0d last", i), {31'b0, dout_last}, {31'b0, vq[i].last});
            end
        end

        // Granted source stalls 5 cycles mid-payload while din1 waits.
        cyc(0, 32'h3, 1, 32'h0, 0, 1);
        chk("stall idle vld", {31'b0, dout_valid}, 32'd0);
        cyc(0, 32'h3, 1, 32'h00AB0000, 1, 1);
        chk_word("stall hdr", 32'h3, 0, 0);
        cyc(0, 32'hE1, 1, 32'h00AB0000, 1, 1);
        chk_word("stall e1", 32'hE1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 32'h0, 0, 32'h00AB0000, 1, 1);
            chk($sformatf("stall%0d vld", k), {31'b0, dout_valid}, 32'd0);
            chk($sformatf("stall%0d rdy1", k), {31'b0, din1_ready}, 32'd0);
            chk($sformatf("stall%0d busy", k), {31'b0, busy}, 32'd1);
        end
        cyc(0, 32'hE2, 1, 32'h00AB0000, 1, 1);
        chk_word("stall e2", 32'hE2, 0, 0);
        cyc(0, 32'hE3, 1, 32'h00AB0000, 1, 1);
        chk_word("stall e3", 32'hE3, 0, 1);
        cyc(0, 32'h0, 0, 32'h00AB0000, 1, 1);
        chk("stall arb busy", {31'b0, busy}, 32'd0);
        cyc(0, 32'h0, 0, 32'h00AB0000, 1, 1);
        chk_word("stall src1", 32'h00AB0000, 1, 1);
        cyc(0, 32'h0, 0, 32'h0, 0, 1);

        // Reset after two of four payload words; the next word becomes a header.
        cyc(0, 32'h4, 1, 32'h0, 0, 1);
        cyc(0, 32'h4, 1, 32'h0, 0, 1);
        chk_word("rst hdr", 32'h4, 0, 0);
        cyc(0, 32'hF1, 1, 32'h0, 0, 1);
        chk_word("rst f1", 32'hF1, 0, 0);
        cyc(0, 32'hF2, 1, 32'h0, 0, 1);
        chk_word("rst f2", 32'hF2, 0, 0);
        cyc(1, 32'hFFFF0001, 1, 32'h0, 1, 1);
        chk("rst rdy0", {31'b0, din0_ready}, 32'd0);
        chk("rst rdy1", {31'b0, din1_ready}, 32'd0);
        chk("rst vld", {31'b0, dout_valid}, 32'd0);
        cyc(0, 32'hFFFF0001, 1, 32'h0, 0, 1);
        chk("post rst busy", {31'b0, busy}, 32'd0);
        chk("post rst vld", {31'b0, dout_valid}, 32'd0);
        cyc(0, 32'hFFFF0001, 1, 32'h0, 0, 1);
        chk_word("new hdr", 32'hFFFF0001, 0, 0);
        cyc(0, 32'h55, 1, 32'h0, 0, 1);
        chk_word("new pay", 32'h55, 0, 1);
        cyc(0, 32'h0, 0, 32'h0, 0, 1);
        chk("end busy", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
